// File: rtl/burst_traffic_master.sv
// burst_traffic_master: write-side traffic generator for async FIFO benches.
// Ports: wclk/wreset_n; start, mode, num_words, burst_len, gap_len, full in;
//        valid, data_in, busy, done, sent_count out.
module burst_traffic_master #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    CNT_WIDTH  = 16,
    parameter int                    LEN_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = 'hB8,
    parameter logic [DATA_WIDTH-1:0] LFSR_SEED  = 1
) (
    input  logic                  wclk,
    input  logic                  wreset_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [CNT_WIDTH-1:0]  num_words,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic [LEN_WIDTH-1:0]  gap_len,
    input  logic                  full,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  sent_count
);

    // An all-zero LFSR state would lock up, so a zero seed becomes 1.
    localparam logic [DATA_WIDTH-1:0] SEED =
        (LFSR_SEED == '0) ? DATA_WIDTH'(1) : LFSR_SEED;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_GAP,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_data;
    logic [CNT_WIDTH-1:0]  r_sent;
    logic [CNT_WIDTH-1:0]  r_num;
    logic [LEN_WIDTH-1:0]  r_bcnt;
    logic [LEN_WIDTH-1:0]  r_gcnt;
    logic [LEN_WIDTH-1:0]  r_blen;
    logic [LEN_WIDTH-1:0]  r_glen;
    logic [1:0]            r_mode;

    logic                  w_accept;
    logic                  w_last;
    logic                  w_burst_end;
    logic [CNT_WIDTH:0]    w_sent_p1;
    logic [LEN_WIDTH:0]    w_bcnt_p1;

    // Mode 3 falls into the incrementing default.
    function automatic logic [DATA_WIDTH-1:0] f_first(
        input logic [1:0] m
    );
        case (m)
            2'd1:    f_first = SEED;
            2'd2:    f_first = DATA_WIDTH'(1);
            default: f_first = '0;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_next(
        input logic [1:0]            m,
        input logic [DATA_WIDTH-1:0] x
    );
        case (m)
            2'd1:    f_next = (x >> 1) ^ (x[0] ? LFSR_TAPS : '0);
            2'd2:    f_next = {x[DATA_WIDTH-2:0], x[DATA_WIDTH-1]};
            default: f_next = x + DATA_WIDTH'(1);
        endcase
    endfunction

    // Widened compares so the +1 cannot wrap into a false match.
    assign w_accept    = (r_state == S_BURST) && !full;
    assign w_sent_p1   = {1'b0, r_sent} + (CNT_WIDTH+1)'(1);
    assign w_last      = (w_sent_p1 == {1'b0, r_num});
    assign w_bcnt_p1   = {1'b0, r_bcnt} + (LEN_WIDTH+1)'(1);
    assign w_burst_end = (r_blen != '0) &&
                         (w_bcnt_p1 == {1'b0, r_blen});

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_next = (num_words == '0) ? S_DONE : S_BURST;
                end
            end
            S_BURST: begin
                if (w_accept) begin
                    if (w_last) begin
                        w_next = S_DONE;
                    end else if (w_burst_end && r_glen != '0) begin
                        w_next = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (r_gcnt <= LEN_WIDTH'(1)) begin
                    w_next = S_BURST;
                end
            end
        endcase
    end

    always_ff @(posedge wclk or negedge wreset_n) begin
        if (!wreset_n) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_sent  <= '0;
            r_num   <= '0;
            r_bcnt  <= '0;
            r_gcnt  <= '0;
            r_blen  <= '0;
            r_glen  <= '0;
            r_mode  <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_mode <= mode;
                        r_num  <= num_words;
                        r_blen <= burst_len;
                        r_glen <= gap_len;
                        r_sent <= '0;
                        r_bcnt <= '0;
                        r_gcnt <= '0;
                        r_data <= f_first(mode);
                    end
                end
                S_BURST: begin
                    if (w_accept) begin
                        if (r_sent != '1) begin
                            r_sent <= r_sent + CNT_WIDTH'(1);
                        end
                        r_data <= f_next(r_mode, r_data);
                        // Counter wraps at burst end whether or not a gap follows.
                        if (w_burst_end) begin
                            r_bcnt <= '0;
                        end else begin
                            r_bcnt <= r_bcnt + LEN_WIDTH'(1);
                        end
                        if (w_next == S_GAP) begin
                            r_gcnt <= r_glen;
                        end
                    end
                end
                S_GAP: begin
                    r_gcnt <= r_gcnt - LEN_WIDTH'(1);
                end
            endcase
        end
    end

    assign valid      = (r_state == S_BURST);
    assign busy       = (r_state == S_BURST) || (r_state == S_GAP);
    assign done       = (r_state == S_DONE);
    assign data_in    = r_data;
    assign sent_count = r_sent;

endmodule

// File: tb/tb_burst_traffic_master.sv
// Scoreboard bench for burst_traffic_master: directed runs push expected
// words; a monitor compares every presented word against the queue head.
module tb_burst_traffic_master;

    logic        wclk = 1'b0;
    logic        wreset_n = 1'b0;
    logic        start = 1'b0;
    logic        full = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] num_words = '0;
    logic [7:0]  burst_len = '0;
    logic [7:0]  gap_len = '0;
    logic        valid;
    logic [7:0]  data_in;
    logic        busy;
    logic        done;
    logic [15:0] sent_count;

    typedef struct packed {
        logic [7:0]  d;
        logic [15:0] c;
    } exp_t;

    exp_t q[$];
    int   errs = 0;
    int   checks = 0;

    logic [63:0] pat;
    logic [7:0]  lfsr_v[6] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
    logic [7:0]  walk_v[9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                               8'h20, 8'h40, 8'h80, 8'h01};

    burst_traffic_master dut (
        .wclk       (wclk),
        .wreset_n   (wreset_n),
        .start      (start),
        .mode       (mode),
        .num_words  (num_words),
        .burst_len  (burst_len),
        .gap_len    (gap_len),
        .full       (full),
        .valid      (valid),
        .data_in    (data_in),
        .busy       (busy),
        .done       (done),
        .sent_count (sent_count)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_inc(input int n);
        for (int i = 0; i < n; i++) begin
            q.push_back('{d: 8'(i), c: 16'(i)});
        end
    endtask

    // Monitor: compare any presented word with the queue head; pop on accept.
    initial begin
        forever begin
            @(negedge wclk);
            #1;
            if (wreset_n && valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_valid: got data %0h expected none",
                             data_in);
                end else begin
                    chk("data_in", 64'(data_in), 64'(q[0].d));
                    chk("sent_live", 64'(sent_count), 64'(q[0].c));
                    if (!full) void'(q.pop_front());
                end
            end
        end
    end

    task automatic run(input string nm, input logic [1:0] m,
                       input int n, input int bl, input int gl,
                       input int st_at, input int st_n, input int mid_at,
                       input int exp_cyc, input int exp_vc,
                       output logic [63:0] p);
        int c;
        int vc;
        @(negedge wclk);
        mode = m;
        num_words = 16'(n);
        burst_len = 8'(bl);
        gap_len = 8'(gl);
        full = 1'b0;
        start = 1'b1;
        @(negedge wclk);
        start = 1'b0;
        p = '0;
        c = 0;
        vc = 0;
        while (!done && c < 200) begin
            p = {p[62:0], valid};
            if (valid) vc++;
            full = valid && c >= st_at && c < st_at + st_n;
            if (c == mid_at) begin
                start = 1'b1;
                mode = 2'd2;
                num_words = 16'd2;
            end else begin
                start = 1'b0;
            end
            c++;
            @(negedge wclk);
        end
        full = 1'b0;
        start = 1'b0;
        chk({nm, "_cycles"}, 64'(c), 64'(exp_cyc));
        chk({nm, "_valid_cycles"}, 64'(vc), 64'(exp_vc));
        chk({nm, "_done"}, 64'(done), 64'd1);
        chk({nm, "_busy"}, 64'(busy), 64'd0);
        chk({nm, "_sent"}, 64'(sent_count), 64'(n));
        chk({nm, "_queue_left"}, 64'(q.size()), 64'd0);
    endtask

    initial begin
        #22;
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sent", 64'(sent_count), 64'd0);
        chk("rst_data", 64'(data_in), 64'd0);
        @(negedge wclk);
        wreset_n = 1'b1;

        push_inc(5);
        run("cont", 2'd0, 5, 0, 0, -1, 0, -1, 5, 5, pat);
        chk("cont_pattern", pat, 64'h1F);

        push_inc(5);
        run("bp", 2'd0, 5, 0, 0, 2, 3, -1, 8, 8, pat);

        push_inc(5);
        run("burst", 2'd0, 5, 2, 3, -1, 0, -1, 11, 5, pat);
        chk("burst_pattern", pat, 64'b110_0011_0001);

        push_inc(5);
        run("nogap", 2'd0, 5, 2, 0, -1, 0, -1, 5, 5, pat);

        for (int i = 0; i < 6; i++) q.push_back('{d: lfsr_v[i], c: 16'(i)});
        run("lfsr", 2'd1, 6, 0, 0, -1, 0, -1, 6, 6, pat);

        for (int i = 0; i < 9; i++) q.push_back('{d: walk_v[i], c: 16'(i)});
        run("walk", 2'd2, 9, 0, 0, -1, 0, -1, 9, 9, pat);

        push_inc(3);
        run("mode3", 2'd3, 3, 0, 0, -1, 0, -1, 3, 3, pat);

        run("zero", 2'd0, 0, 0, 0, -1, 0, -1, 0, 0, pat);
        chk("zero_pattern", pat, 64'd0);

        push_inc(6);
        run("mid", 2'd0, 6, 0, 0, -1, 0, 2, 6, 6, pat);

        // Reset in the middle of a long burst.
        @(negedge wclk);
        mode = 2'd0;
        num_words = 16'd20;
        burst_len = '0;
        gap_len = '0;
        push_inc(20);
        start = 1'b1;
        @(negedge wclk);
        start = 1'b0;
        repeat (3) @(negedge wclk);
        #3;
        wreset_n = 1'b0;
        q.delete();
        #1;
        chk("arst_valid", 64'(valid), 64'd0);
        chk("arst_sent", 64'(sent_count), 64'd0);
        chk("arst_data", 64'(data_in), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        @(negedge wclk);
        wreset_n = 1'b1;

        push_inc(3);
        run("restart", 2'd0, 3, 0, 0, -1, 0, -1, 3, 3, pat);

        repeat (2) @(negedge wclk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
